regfile_wb_sched: RTL and testbench

Write-back scheduler for the 32x32 integer register file, which has a single write port. It arbitrates among NREQ result producers (ALU, load unit, mul/div, CSR/AMO) for that port using round-robin and drives a registered write port into the register file. It also keeps a per-register busy scoreboard so decode can stall on operands whose producer has not yet written back.

---
 rtl/regfile_wb_sched.sv | 130 +++++++++++++
 tb/tb_regfile_wb_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin arbitration of result producers onto the
// single register-file write port, plus the per-register busy scoreboard.
module regfile_wb_sched #(
   parameter int NREQ  = 4,
   parameter int XLEN  = 32,
   parameter int PTR_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid_i,
   input  logic [5*NREQ-1:0]    req_rd_i,
   input  logic [XLEN*NREQ-1:0] req_wd_i,
   output logic [NREQ-1:0]      req_ready_o,
   input  logic                 issue_valid_i,
   input  logic [4:0]           issue_rd_i,
   input  logic [4:0]           rs1_i,
   input  logic [4:0]           rs2_i,
   output logic                 rs1_busy_o,
   output logic                 rs2_busy_o,
   output logic                 rf_we_o,
   output logic [4:0]           rf_rd_o,
   output logic [XLEN-1:0]      rf_wd_o,
   output logic [31:0]          busy_vec_o
);

   localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [31:0]      busy_q, busy_d;
   logic             rf_we_q, rf_we_d;
   logic [4:0]       rf_rd_q, rf_rd_d;
   logic [XLEN-1:0]  rf_wd_q, rf_wd_d;

   logic             grantValid;
   logic [PTR_W-1:0] grantIdx;
   logic [4:0]       grantRd;
   logic [XLEN-1:0]  grantWd;
   logic [PTR_W:0]   cand;

   // Scan starts one past the last winner and wraps, so the last winner
   // becomes lowest priority on the next arbitration.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      cand       = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + (PTR_W+1)'(k + 1);
         if (cand >= NREQ_W) begin
            cand = cand - NREQ_W;
         end
         if (!grantValid && req_valid_i[cand[PTR_W-1:0]]) begin
            grantValid = 1'b1;
            grantIdx   = cand[PTR_W-1:0];
         end
      end
      if (!rst) begin
         grantValid = 1'b0;
      end
   end

   always_comb begin
      grantRd = '0;
      grantWd = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grantIdx == PTR_W'(i)) begin
            grantRd = req_rd_i[5*i +: 5];
            grantWd = req_wd_i[XLEN*i +: XLEN];
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      if (grantValid) begin
         req_ready_o[grantIdx] = 1'b1;
      end
   end

   // A write to x0 is still granted so the producer drains, but never strobes
   // the register file.
   always_comb begin
      ptr_d   = ptr_q;
      rf_we_d = 1'b0;
      rf_rd_d = rf_rd_q;
      rf_wd_d = rf_wd_q;
      if (grantValid) begin
         ptr_d   = grantIdx;
         rf_we_d = (grantRd != 5'd0);
         rf_rd_d = grantRd;
         rf_wd_d = grantWd;
      end
   end

   // Set is applied after clear so a newer producer issued in the same cycle
   // keeps the register busy over the older one's write-back.
   always_comb begin
      busy_d = busy_q;
      if (grantValid) begin
         busy_d[grantRd] = 1'b0;
      end
      if (issue_valid_i && (issue_rd_i != 5'd0)) begin
         busy_d[issue_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q   <= PTR_W'(NREQ - 1);
         busy_q  <= '0;
         rf_we_q <= 1'b0;
         rf_rd_q <= '0;
         rf_wd_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         rf_we_q <= rf_we_d;
         rf_rd_q <= rf_rd_d;
         rf_wd_q <= rf_wd_d;
      end
   end

   assign rs1_busy_o = busy_q[rs1_i] & (rs1_i != 5'd0);
   assign rs2_busy_o = busy_q[rs2_i] & (rs2_i != 5'd0);
   assign rf_we_o    = rf_we_q;
   assign rf_rd_o    = rf_rd_q;
   assign rf_wd_o    = rf_wd_q;
   assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: arbitration order, write port timing,
// scoreboard set/clear and asynchronous reset.
module tb_regfile_wb_sched;

   localparam int NREQ = 4;
   localparam int XLEN = 32;

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      reqValid;
   logic [5*NREQ-1:0]    reqRd;
   logic [XLEN*NREQ-1:0] reqWd;
   logic [NREQ-1:0]      reqReady;
   logic                 issueValid;
   logic [4:0]           issueRd;
   logic [4:0]           rs1;
   logic [4:0]           rs2;
   logic                 rs1Busy;
   logic                 rs2Busy;
   logic                 rfWe;
   logic [4:0]           rfRd;
   logic [XLEN-1:0]      rfWd;
   logic [31:0]          busyVec;

   int vectors;
   int miscompares;

   regfile_wb_sched #(.NREQ(NREQ), .XLEN(XLEN), .PTR_W(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_i   (reqValid),
      .req_rd_i      (reqRd),
      .req_wd_i      (reqWd),
      .req_ready_o   (reqReady),
      .issue_valid_i (issueValid),
      .issue_rd_i    (issueRd),
      .rs1_i         (rs1),
      .rs2_i         (rs2),
      .rs1_busy_o    (rs1Busy),
      .rs2_busy_o    (rs2Busy),
      .rf_we_o       (rfWe),
      .rf_rd_o       (rfRd),
      .rf_wd_o       (rfWd),
      .busy_vec_o    (busyVec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic [4:0] rd,
                                input logic [XLEN-1:0] wd);
      reqRd[5*idx +: 5]       = rd;
      reqWd[XLEN*idx +: XLEN] = wd;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      reqValid    = '0;
      reqRd       = '0;
      reqWd       = '0;
      issueValid  = 1'b0;
      issueRd     = '0;
      rs1         = '0;
      rs2         = '0;

      // Reset state
      #3;
      checkOutput("reset_rf_we", {31'd0, rfWe}, 32'd0);
      checkOutput("reset_rf_rd", {27'd0, rfRd}, 32'd0);
      checkOutput("reset_rf_wd", rfWd, 32'd0);
      checkOutput("reset_busy", busyVec, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Single write from requester 0
      reqValid = 4'b0001;
      applyStimulus(0, 5'd5, 32'hDEADBEEF);
      #1;
      checkOutput("single_ready", {28'd0, reqReady}, 32'h1);
      @(negedge clk);
      reqValid = '0;
      checkOutput("single_we", {31'd0, rfWe}, 32'd1);
      checkOutput("single_rd", {27'd0, rfRd}, 32'd5);
      checkOutput("single_wd", rfWd, 32'hDEADBEEF);
      #1;
      checkOutput("single_ready_drop", {28'd0, reqReady}, 32'h0);
      @(negedge clk);
      checkOutput("single_we_low", {31'd0, rfWe}, 32'd0);
      checkOutput("single_rd_hold", {27'd0, rfRd}, 32'd5);

      // Round robin with all requesters valid, starting from a fresh reset
      rst = 1'b0;
      #1;
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         applyStimulus(i, 5'(10 + i), 32'h100 + 32'(i));
      end
      reqValid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         #1;
         checkOutput($sformatf("rr_ready_%0d", c), {28'd0, reqReady}, 32'(1 << (c % 4)));
         @(negedge clk);
         checkOutput($sformatf("rr_we_%0d", c), {31'd0, rfWe}, 32'd1);
         checkOutput($sformatf("rr_rd_%0d", c), {27'd0, rfRd}, 32'(10 + (c % 4)));
         checkOutput($sformatf("rr_wd_%0d", c), rfWd, 32'h100 + 32'(c % 4));
      end
      reqValid = '0;

      // Issue rd=7, then requester 2 writes it back
      issueValid = 1'b1;
      issueRd    = 5'd7;
      @(negedge clk);
      issueValid = 1'b0;
      rs1        = 5'd7;
      #1;
      checkOutput("sb_busy_vec7", busyVec, 32'h0000_0080);
      checkOutput("sb_rs1_busy", {31'd0, rs1Busy}, 32'd1);
      reqValid = 4'b0100;
      applyStimulus(2, 5'd7, 32'hCAFE0007);
      #1;
      checkOutput("sb_grant2", {28'd0, reqReady}, 32'h4);
      checkOutput("sb_rs1_busy_grant", {31'd0, rs1Busy}, 32'd1);
      @(negedge clk);
      reqValid = '0;
      checkOutput("sb_rs1_free", {31'd0, rs1Busy}, 32'd0);
      checkOutput("sb_we7", {31'd0, rfWe}, 32'd1);
      checkOutput("sb_rd7", {27'd0, rfRd}, 32'd7);

      // Older producer of rd=9 writes back while a newer one issues: set wins
      issueValid = 1'b1;
      issueRd    = 5'd9;
      @(negedge clk);
      reqValid = 4'b1000;
      applyStimulus(3, 5'd9, 32'h0000_0099);
      #1;
      checkOutput("setwin_grant3", {28'd0, reqReady}, 32'h8);
      @(negedge clk);
      issueValid = 1'b0;
      reqValid   = '0;
      checkOutput("setwin_busy9", busyVec, 32'h0000_0200);

      // rd=0 write drains without strobing; issue to x0 never sets busy
      reqValid   = 4'b0010;
      applyStimulus(1, 5'd0, 32'h0000_1234);
      issueValid = 1'b1;
      issueRd    = 5'd0;
      rs2        = 5'd0;
      #1;
      checkOutput("x0_ready", {28'd0, reqReady}, 32'h2);
      checkOutput("x0_rs2_busy", {31'd0, rs2Busy}, 32'd0);
      @(negedge clk);
      reqValid   = '0;
      issueValid = 1'b0;
      checkOutput("x0_we", {31'd0, rfWe}, 32'd0);
      checkOutput("x0_busy", busyVec, 32'h0000_0200);
      rs2 = 5'd9;
      #1;
      checkOutput("x0_rs2_busy9", {31'd0, rs2Busy}, 32'd1);

      // Build busy_vec = 0xF00, start a write, then reset mid-cycle
      issueValid = 1'b1;
      issueRd    = 5'd8;
      @(negedge clk);
      issueRd    = 5'd10;
      @(negedge clk);
      issueRd    = 5'd11;
      @(negedge clk);
      issueValid = 1'b0;
      checkOutput("rst_pre_busy", busyVec, 32'h0000_0F00);
      for (int i = 0; i < NREQ; i++) begin
         applyStimulus(i, 5'(20 + i), 32'h200 + 32'(i));
      end
      reqValid = 4'b1111;
      #1;
      checkOutput("rst_pre_ready", {28'd0, reqReady}, 32'h4);
      @(negedge clk);
      checkOutput("rst_pre_we", {31'd0, rfWe}, 32'd1);
      checkOutput("rst_pre_rd", {27'd0, rfRd}, 32'd22);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("rst_busy", busyVec, 32'd0);
      checkOutput("rst_we", {31'd0, rfWe}, 32'd0);
      checkOutput("rst_rd", {27'd0, rfRd}, 32'd0);
      checkOutput("rst_ready", {28'd0, reqReady}, 32'h0);
      reqValid = '0;
      @(negedge clk);
      rst      = 1'b1;
      reqValid = 4'b1111;
      #1;
      checkOutput("post_rst_ready", {28'd0, reqReady}, 32'h1);
      @(negedge clk);
      reqValid = '0;
      checkOutput("post_rst_rd", {27'd0, rfRd}, 32'd20);
      checkOutput("post_rst_wd", rfWd, 32'h200);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
